ls_stage_unit: RTL

Load-store stage of the 5-stage pipeline. It sits between the EX_LS and LS_WB pipeline registers. It takes the instruction held in EX_LS, runs any load/store over a valid/ready memory request channel, waits for the response, and fills the LS_WB register. It produces LS_MON_ls_valid, the completion pulse the hazard monitor uses to release the EX stage and to allow jump flushes.

---
 rtl/ls_stage_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ls_stage_unit.sv
// ls_stage_unit: load-store stage between the EX_LS and LS_WB pipeline registers.
// Issues the load/store held in EX_LS over a valid/ready request channel,
// waits for the response, then fills LS_WB. LS_MON_ls_valid pulses on completion.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   EX_LS_reg_*                     instruction held in EX_LS (stable while an access is pending)
//   mem_req_* / mem_rsp_*           memory request (valid/ready) and response channels
//   LS_MON_ls_valid                 access-complete pulse for the hazard monitor
//   ls_misalign                     current access crosses the 8-byte boundary
//   LS_WB_reg_*                     registered writeback payload
module ls_stage_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned MASKW = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EX_LS_reg_execute_valid,
  input  logic             EX_LS_reg_load_sign_flag,
  input  logic             EX_LS_reg_store_sign_flag,
  input  logic [1:0]       EX_LS_reg_ls_size,
  input  logic             EX_LS_reg_load_unsigned,
  input  logic [XLEN-1:0]  EX_LS_reg_result,
  input  logic [XLEN-1:0]  EX_LS_reg_store_data,
  input  logic [4:0]       EX_LS_reg_rd,
  input  logic             EX_LS_reg_dest_wen,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic             mem_req_wen,
  output logic [XLEN-1:0]  mem_req_wdata,
  output logic [MASKW-1:0] mem_req_wmask,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_rdata,
  output logic             LS_MON_ls_valid,
  output logic             ls_misalign,
  output logic             LS_WB_reg_ls_valid,
  output logic [4:0]       LS_WB_reg_rd,
  output logic             LS_WB_reg_dest_wen,
  output logic [XLEN-1:0]  LS_WB_reg_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             w_mem_op;
  logic [2:0]       w_off;
  logic [5:0]       w_shamt;
  logic [3:0]       w_bytes;
  logic [7:0]       w_size_mask;
  logic [3:0]       w_end;
  logic [MASKW-1:0] w_wmask;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_ld_shift;
  logic [XLEN-1:0]  w_ld_ext;
  logic             w_req_valid;
  logic             w_ls_done;

  assign w_mem_op = EX_LS_reg_execute_valid &
                    (EX_LS_reg_load_sign_flag | EX_LS_reg_store_sign_flag);
  assign w_off    = EX_LS_reg_result[2:0];
  assign w_shamt  = {w_off, 3'b000};

  // Access size to byte count and base byte mask
  always_comb begin
    w_bytes     = 4'd8;
    w_size_mask = 8'hFF;
    case (EX_LS_reg_ls_size)
      2'd0: begin w_bytes = 4'd1; w_size_mask = 8'h01; end
      2'd1: begin w_bytes = 4'd2; w_size_mask = 8'h03; end
      2'd2: begin w_bytes = 4'd4; w_size_mask = 8'h0F; end
      default: begin w_bytes = 4'd8; w_size_mask = 8'hFF; end
    endcase
  end

  // Lane placement; bytes shifted past the top of the bus are dropped
  assign w_wmask = MASKW'(w_size_mask) << w_off;
  assign w_wdata = EX_LS_reg_store_data << w_shamt;
  assign w_end   = 4'({1'b0, w_off}) + w_bytes;

  // Load data: align to bit 0, cut to size, extend
  assign w_ld_shift = mem_rsp_rdata >> w_shamt;
  always_comb begin
    w_ld_ext = w_ld_shift;
    case (EX_LS_reg_ls_size)
      2'd0: w_ld_ext = EX_LS_reg_load_unsigned ? XLEN'(w_ld_shift[7:0])
                     : {{(XLEN-8){w_ld_shift[7]}}, w_ld_shift[7:0]};
      2'd1: w_ld_ext = EX_LS_reg_load_unsigned ? XLEN'(w_ld_shift[15:0])
                     : {{(XLEN-16){w_ld_shift[15]}}, w_ld_shift[15:0]};
      2'd2: w_ld_ext = EX_LS_reg_load_unsigned ? XLEN'(w_ld_shift[31:0])
                     : {{(XLEN-32){w_ld_shift[31]}}, w_ld_shift[31:0]};
      default: w_ld_ext = w_ld_shift;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and handshake outputs; everything held at 0 during reset
  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_ls_done   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            w_req_valid = 1'b1;
            w_next      = mem_req_ready ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          w_req_valid = 1'b1;
          if (mem_req_ready) w_next = S_RESP;
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            w_ls_done = 1'b1;
            w_next    = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign mem_req_valid   = w_req_valid;
  assign LS_MON_ls_valid = w_ls_done;
  assign ls_misalign     = rst_n & w_mem_op & (w_end > 4'd8);

  // Request payload is driven only while a request is presented
  assign mem_req_addr  = w_req_valid ? {EX_LS_reg_result[XLEN-1:3], 3'b000} : '0;
  assign mem_req_wen   = w_req_valid & EX_LS_reg_store_sign_flag;
  assign mem_req_wdata = w_req_valid ? w_wdata : '0;
  assign mem_req_wmask = (w_req_valid & EX_LS_reg_store_sign_flag) ? w_wmask : '0;

  // LS_WB register: bubble while an access is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LS_WB_reg_ls_valid <= 1'b0;
      LS_WB_reg_rd       <= 5'd0;
      LS_WB_reg_dest_wen <= 1'b0;
      LS_WB_reg_result   <= '0;
    end else if (w_mem_op) begin
      LS_WB_reg_ls_valid <= w_ls_done;
      if (w_ls_done) begin
        LS_WB_reg_rd       <= EX_LS_reg_rd;
        LS_WB_reg_dest_wen <= EX_LS_reg_dest_wen;
        LS_WB_reg_result   <= EX_LS_reg_load_sign_flag ? w_ld_ext : EX_LS_reg_result;
      end
    end else begin
      LS_WB_reg_ls_valid <= EX_LS_reg_execute_valid;
      if (EX_LS_reg_execute_valid) begin
        LS_WB_reg_rd       <= EX_LS_reg_rd;
        LS_WB_reg_dest_wen <= EX_LS_reg_dest_wen;
        LS_WB_reg_result   <= EX_LS_reg_result;
      end
    end
  end

endmodule
